// File: rtl/iomem_pkg.sv
// Shared definitions for the picosoc iomem router.
//   - iomem_state_t : router FSM encoding (IDLE / ACTIVE / RESP)
//   - page field bounds within the iomem address
//   - lowest page the router will claim and default error read data
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } iomem_state_t;

  localparam int unsigned IOMEM_PAGE_MSB = 31;
  localparam int unsigned IOMEM_PAGE_LSB = 24;

  // Pages below this belong to memory, never to the router.
  localparam logic [7:0]  IOMEM_MIN_PAGE = 8'h03;
  localparam logic [31:0] IOMEM_ERR_DATA = 32'hDEAD_BEEF;

  function automatic logic [7:0] iomem_page(input logic [31:0] addr);
    return addr[IOMEM_PAGE_MSB:IOMEM_PAGE_LSB];
  endfunction

endpackage

// File: rtl/iomem_watchdog.sv
// Per-access watchdog for the iomem router.
//   clk2, resetn : clock, synchronous active-low reset
//   clear        : reload counter to zero (start of a new access)
//   enable       : count one waiting cycle
//   expired      : counter has reached TIMEOUT-1
module iomem_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk2,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count;

  always_ff @(posedge clk2) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 16'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/iomem_router.sv
// Shares the picosoc iomem port among NUM_SLAVES peripheral slots.
// Slot i decodes page addr[31:24] == BASE_PAGE+i. Requests are registered
// onto the broadcast s_* bus with a one-hot s_valid; a watchdog forces an
// ERR_DATA response if the slave never answers. Unmapped pages (>= 8'h03)
// get an immediate error response when DECODE_ALL=1.
//   clk2, resetn        : clock, synchronous active-low reset
//   m_valid/m_ready     : picosoc request / one-cycle completion pulse
//   m_wstrb/m_addr/m_wdata/m_rdata : picosoc request fields and read data
//   s_valid/s_ready     : per-slot request / completion
//   s_wstrb/s_addr/s_wdata : registered request fields, broadcast
//   s_rdata             : packed slave read data, slot i at [32*i+31:32*i]
//   clear_err           : clears err_count
//   err_count/err_addr  : saturating error count, address of last error
module iomem_router
  import iomem_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [7:0]  BASE_PAGE  = 8'h03,
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          DECODE_ALL = 1'b1,
  parameter logic [31:0] ERR_DATA   = IOMEM_ERR_DATA
) (
  input  logic                       clk2,
  input  logic                       resetn,
  input  logic                       m_valid,
  output logic                       m_ready,
  input  logic [3:0]                 m_wstrb,
  input  logic [31:0]                m_addr,
  input  logic [31:0]                m_wdata,
  output logic [31:0]                m_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic [3:0]                 s_wstrb,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic [32*NUM_SLAVES-1:0]   s_rdata,
  input  logic                       clear_err,
  output logic [7:0]                 err_count,
  output logic [31:0]                err_addr
);

  localparam logic [NUM_SLAVES-1:0] SLOT0 = NUM_SLAVES'(1);

  iomem_state_t state, state_next;

  logic [7:0]  req_page;
  logic [8:0]  page_off;
  logic        in_range;
  logic        unmapped;
  logic [2:0]  slot_idx;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  logic accept;
  logic resp_slave;
  logic err_timeout;
  logic err_unmapped;
  logic err_event;
  logic wd_enable;
  logic wd_expired;

  // Address decode
  assign req_page = iomem_page(m_addr);
  assign page_off = {1'b0, req_page} - {1'b0, BASE_PAGE};
  assign in_range = (req_page >= BASE_PAGE) && (page_off < 9'(NUM_SLAVES));
  assign unmapped = !in_range && (req_page >= IOMEM_MIN_PAGE);

  // Selected slot's ready and read data
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (slot_idx == 3'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  iomem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk2    (clk2),
    .resetn  (resetn),
    .clear   (accept),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk2) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // m_ready is registered out of RESP, so it is high in the cycle after RESP
  // while the FSM is already in IDLE; IDLE ignores m_valid during that cycle
  // because picosoc only drops valid on the edge where it samples ready.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    resp_slave   = 1'b0;
    err_timeout  = 1'b0;
    err_unmapped = 1'b0;
    wd_enable    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m_valid && !m_ready) begin
          if (in_range) begin
            accept     = 1'b1;
            state_next = ST_ACTIVE;
          end else if (DECODE_ALL && unmapped) begin
            err_unmapped = 1'b1;
            state_next   = ST_RESP;
          end
        end
      end
      ST_ACTIVE: begin
        if (sel_ready) begin
          resp_slave = 1'b1;
          state_next = ST_RESP;
        end else if (wd_expired) begin
          err_timeout = 1'b1;
          state_next  = ST_RESP;
        end else begin
          wd_enable = 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign err_event = err_timeout | err_unmapped;

  always_ff @(posedge clk2) begin
    if (!resetn) begin
      m_ready   <= 1'b0;
      m_rdata   <= '0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      slot_idx  <= '0;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      m_ready <= (state == ST_RESP);

      if (accept) begin
        slot_idx <= page_off[2:0];
        s_addr   <= m_addr;
        s_wdata  <= m_wdata;
        s_wstrb  <= m_wstrb;
        s_valid  <= SLOT0 << page_off[2:0];
      end

      if (resp_slave) begin
        m_rdata <= sel_rdata;
        s_valid <= '0;
      end

      if (err_timeout) begin
        m_rdata  <= ERR_DATA;
        err_addr <= s_addr;
        s_valid  <= '0;
      end

      if (err_unmapped) begin
        m_rdata  <= ERR_DATA;
        err_addr <= m_addr;
      end

      if (clear_err) begin
        err_count <= {7'd0, err_event};
      end else if (err_event && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_iomem_router.sv
`timescale 1ns/1ps
module tb_iomem_router;

  localparam int unsigned NS = 4;

  logic            clk2 = 1'b0;
  logic            resetn = 1'b0;
  logic            m_valid = 1'b0;
  logic            m_valid_nd = 1'b0;
  logic [3:0]      m_wstrb = '0;
  logic [31:0]     m_addr = '0;
  logic [31:0]     m_wdata = '0;
  logic [NS-1:0]   s_ready = '0;
  logic [32*NS-1:0] s_rdata = '0;
  logic            clear_err = 1'b0;

  logic            m_ready, m_ready_nd;
  logic [31:0]     m_rdata, m_rdata_nd;
  logic [NS-1:0]   s_valid, s_valid_nd;
  logic [3:0]      s_wstrb, s_wstrb_nd;
  logic [31:0]     s_addr, s_addr_nd, s_wdata, s_wdata_nd;
  logic [7:0]      err_count, err_count_nd;
  logic [31:0]     err_addr, err_addr_nd;

  iomem_router #(
    .NUM_SLAVES (NS),
    .BASE_PAGE  (8'h03),
    .TIMEOUT    (16),
    .DECODE_ALL (1'b1),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk2 (clk2), .resetn (resetn),
    .m_valid (m_valid), .m_ready (m_ready), .m_wstrb (m_wstrb),
    .m_addr (m_addr), .m_wdata (m_wdata), .m_rdata (m_rdata),
    .s_valid (s_valid), .s_ready (s_ready), .s_wstrb (s_wstrb),
    .s_addr (s_addr), .s_wdata (s_wdata), .s_rdata (s_rdata),
    .clear_err (clear_err), .err_count (err_count), .err_addr (err_addr)
  );

  iomem_router #(
    .NUM_SLAVES (NS),
    .BASE_PAGE  (8'h03),
    .TIMEOUT    (16),
    .DECODE_ALL (1'b0),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut_nd (
    .clk2 (clk2), .resetn (resetn),
    .m_valid (m_valid_nd), .m_ready (m_ready_nd), .m_wstrb (m_wstrb),
    .m_addr (m_addr), .m_wdata (m_wdata), .m_rdata (m_rdata_nd),
    .s_valid (s_valid_nd), .s_ready (s_ready), .s_wstrb (s_wstrb_nd),
    .s_addr (s_addr_nd), .s_wdata (s_wdata_nd), .s_rdata (s_rdata),
    .clear_err (clear_err), .err_count (err_count_nd), .err_addr (err_addr_nd)
  );

  always #5 clk2 = ~clk2;

  int cyc = 0;
  initial forever begin
    @(posedge clk2);
    cyc++;
  end

  typedef struct {
    logic [31:0] rd;
    logic [7:0]  cnt;
    logic [31:0] ea;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int ready_pulses = 0;
  int nd_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every m_ready pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk2);
      if (m_ready_nd === 1'b1) nd_pulses++;
      if (m_ready === 1'b1) begin
        ready_pulses++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got m_ready=1 rdata %h, expected no response", m_rdata);
        end else begin
          e = sb.pop_front();
          chk("m_rdata", m_rdata, e.rd);
          chk("err_count", 32'(err_count), 32'(e.cnt));
          chk("err_addr", err_addr, e.ea);
          chk("ready_edge", 32'(cyc), 32'(e.edge_n));
        end
      end
    end
  end

  // One picosoc access. d = cycles of s_valid before the slave raises
  // s_ready (0 = same cycle s_valid appears, -1 = never). lat = edges from
  // the sampling edge to the edge after which m_ready is high.
  task automatic access(input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input int d,
                        input logic [31:0] sdata, input logic [31:0] exp_rd,
                        input logic [7:0] exp_cnt, input logic [31:0] exp_ea,
                        input int lat, input int exp_sv, input logic clr);
    logic [7:0]    pg;
    logic [NS-1:0] onehot;
    exp_t          e;
    int            sv;
    bit            got;
    pg = addr[31:24];
    onehot = '0;
    if (pg >= 8'h03 && pg < 8'h07) begin
      onehot[pg - 8'h03] = 1'b1;
      s_rdata[32*(pg - 8'h03) +: 32] = sdata;
    end
    @(negedge clk2);
    m_valid = 1'b1; m_addr = addr; m_wstrb = wstrb; m_wdata = wdata;
    clear_err = clr;
    e.rd = exp_rd; e.cnt = exp_cnt; e.ea = exp_ea; e.edge_n = cyc + 1 + lat;
    sb.push_back(e);
    sv = 0;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk2);
      clear_err = 1'b0;
      if (s_valid != '0) begin
        sv++;
        chk("s_valid_onehot", 32'(s_valid), 32'(onehot));
        chk("s_addr", s_addr, addr);
        chk("s_wdata", s_wdata, wdata);
        chk("s_wstrb", 32'(s_wstrb), 32'(wstrb));
      end
      if (s_valid != '0 && d >= 0 && sv == d + 1) s_ready = onehot;
      else if (s_valid != '0 && d >= 2 && sv == 1) s_ready = ~onehot;
      else s_ready = '0;
      if (m_ready === 1'b1) begin
        got = 1;
        m_valid = 1'b0;
      end
    end
    s_ready = '0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no m_ready for addr %h, expected one", addr);
      m_valid = 1'b0;
    end
    chk("s_valid_cycles", 32'(sv), 32'(exp_sv));
  endtask

  int ecnt;
  int p0;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk2);
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    resetn = 1'b1;

    // Reads of slot 0: slave answers immediately, then one cycle later.
    access(32'h0300_0000, 4'b0000, 32'h0, 0, 32'h0000_00A5, 32'h0000_00A5, 8'd0, 32'h0, 2, 1, 1'b0);
    access(32'h0300_0000, 4'b0000, 32'h0, 1, 32'h0000_00A5, 32'h0000_00A5, 8'd0, 32'h0, 3, 2, 1'b0);
    repeat (3) @(negedge clk2);
    chk("rdata_hold", m_rdata, 32'h0000_00A5);

    // Write to slot 1; other slots raise ready in the first waiting cycle.
    access(32'h0400_0010, 4'b0011, 32'h1234_5678, 3, 32'h1111_2222, 32'h1111_2222, 8'd0, 32'h0, 5, 4, 1'b0);

    // Slot 2 never answers.
    access(32'h0500_0000, 4'b0000, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 8'd1, 32'h0500_0000, 17, 16, 1'b0);

    // Ready in the same cycle the watchdog expires.
    access(32'h0600_0004, 4'b0000, 32'h0, 15, 32'h7777_8888, 32'h7777_8888, 8'd1, 32'h0500_0000, 17, 16, 1'b0);

    // Unmapped pages.
    access(32'h2000_0000, 4'b0000, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 8'd2, 32'h2000_0000, 1, 0, 1'b0);
    access(32'h0700_0000, 4'b1111, 32'hCAFE_0000, -1, 32'h0, 32'hDEAD_BEEF, 8'd3, 32'h0700_0000, 1, 0, 1'b0);

    // Page below the router's range: ignored.
    @(negedge clk2);
    p0 = ready_pulses;
    m_valid = 1'b1; m_addr = 32'h0100_0000; m_wstrb = 4'b0000;
    repeat (8) @(negedge clk2);
    chk("low_page_no_ready", 32'(ready_pulses - p0), 32'd0);
    chk("low_page_no_svalid", 32'(s_valid), 32'd0);
    m_valid = 1'b0;

    // DECODE_ALL=0 instance ignores an unmapped page.
    @(negedge clk2);
    m_valid_nd = 1'b1; m_addr = 32'h2000_0000;
    repeat (8) @(negedge clk2);
    chk("nodecode_no_ready", 32'(nd_pulses), 32'd0);
    chk("nodecode_err_count", 32'(err_count_nd), 32'd0);
    m_valid_nd = 1'b0;

    // Saturate err_count.
    ecnt = 3;
    for (int i = 0; i < 300; i++) begin
      ecnt = (ecnt < 255) ? ecnt + 1 : 255;
      access(32'h2000_0000, 4'b0000, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 8'(ecnt), 32'h2000_0000, 1, 0, 1'b0);
    end
    chk("err_saturated", 32'(err_count), 32'd255);

    // clear_err in the same cycle as a new error.
    access(32'h0900_0000, 4'b0000, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 8'd1, 32'h0900_0000, 1, 0, 1'b1);

    // Reset while a slot-1 access is waiting.
    @(negedge clk2);
    m_valid = 1'b1; m_addr = 32'h0400_0000; m_wstrb = 4'b0000;
    repeat (3) @(negedge clk2);
    chk("pre_reset_s_valid", 32'(s_valid), 32'b0010);
    resetn = 1'b0;
    m_valid = 1'b0;
    @(negedge clk2);
    chk("mid_rst_s_valid", 32'(s_valid), 32'd0);
    chk("mid_rst_m_ready", 32'(m_ready), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_err_addr", err_addr, 32'd0);
    resetn = 1'b1;
    access(32'h0300_0008, 4'b0000, 32'h0, 1, 32'h5A5A_0001, 32'h5A5A_0001, 8'd0, 32'h0, 3, 2, 1'b0);

    // clear_err on its own.
    access(32'h0800_0000, 4'b0000, 32'h0, -1, 32'h0, 32'hDEAD_BEEF, 8'd1, 32'h0800_0000, 1, 0, 1'b0);
    @(negedge clk2);
    clear_err = 1'b1;
    @(negedge clk2);
    clear_err = 1'b0;
    chk("clear_only", 32'(err_count), 32'd0);

    repeat (4) @(negedge clk2);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
